// File: rtl/reg_file_gen_if.sv
// rtl/reg_file_gen_if.sv - write/read/control bundle for the register file
interface reg_file_gen_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [DATA_WIDTH-1:0] WRITEDATA0;
    logic [ADDR_WIDTH-1:0] WRITEREG0;
    logic                  WRITEENABLE0;
    logic [DATA_WIDTH-1:0] WRITEDATA1;
    logic [ADDR_WIDTH-1:0] WRITEREG1;
    logic                  WRITEENABLE1;
    logic [ADDR_WIDTH-1:0] READREG1;
    logic [ADDR_WIDTH-1:0] READREG2;
    logic                  CLEAR;
    logic                  CONFLICT_CLR;
    logic [DATA_WIDTH-1:0] REGOUT1;
    logic [DATA_WIDTH-1:0] REGOUT2;
    logic                  BUSY;
    logic                  CONFLICT;

    modport slave (
        input  WRITEDATA0, WRITEREG0, WRITEENABLE0,
        input  WRITEDATA1, WRITEREG1, WRITEENABLE1,
        input  READREG1, READREG2, CLEAR, CONFLICT_CLR,
        output REGOUT1, REGOUT2, BUSY, CONFLICT
    );

    modport master (
        output WRITEDATA0, WRITEREG0, WRITEENABLE0,
        output WRITEDATA1, WRITEREG1, WRITEENABLE1,
        output READREG1, READREG2, CLEAR, CONFLICT_CLR,
        input  REGOUT1, REGOUT2, BUSY, CONFLICT
    );
endinterface

// File: rtl/reg_file_gen.sv
// rtl/reg_file_gen.sv - parametrised 2R/2W register file with forwarding and clear sweep
module reg_file_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int ZERO_REG   = 0,
    parameter int BYPASS     = 1
) (
    input logic         CLK,
    input logic         RESET,
    reg_file_gen_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state, state_next;
    logic [ADDR_WIDTH:0]   idx;
    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic                  busy;
    logic                  we0_eff, we1_eff, conflict_hit, fwd_en;
    logic [ADDR_WIDTH-1:0] rd_addr [2];
    logic [DATA_WIDTH-1:0] rd_data [2];

    assign busy = (state == SWEEP);

    // Writes to a hardwired zero register vanish before they can conflict or forward.
    assign we0_eff = bus.WRITEENABLE0 && !busy &&
                     !((ZERO_REG != 0) && (bus.WRITEREG0 == '0));
    assign we1_eff = bus.WRITEENABLE1 && !busy &&
                     !((ZERO_REG != 0) && (bus.WRITEREG1 == '0));
    assign conflict_hit = we0_eff && we1_eff && (bus.WRITEREG0 == bus.WRITEREG1);
    assign fwd_en = (BYPASS != 0) && !busy && !RESET;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (busy) begin
                regs[idx[ADDR_WIDTH-1:0]] <= '0;
                idx <= idx + 1'b1;
            end else begin
                if (bus.CLEAR) idx <= '0;
                // Port 1 is assigned last so it wins a same-address collision.
                if (we0_eff) regs[bus.WRITEREG0] <= bus.WRITEDATA0;
                if (we1_eff) regs[bus.WRITEREG1] <= bus.WRITEDATA1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.CLEAR) state_next = SWEEP;
            SWEEP:   if (idx == LAST_IDX) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.CONFLICT <= 1'b0;
        end else if (conflict_hit) begin
            bus.CONFLICT <= 1'b1;
        end else if (bus.CONFLICT_CLR) begin
            bus.CONFLICT <= 1'b0;
        end
    end

    assign rd_addr[0] = bus.READREG1;
    assign rd_addr[1] = bus.READREG2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs[rd_addr[p]];
            if (fwd_en && we1_eff && (bus.WRITEREG1 == rd_addr[p])) begin
                rd_data[p] = bus.WRITEDATA1;
            end else if (fwd_en && we0_eff && (bus.WRITEREG0 == rd_addr[p])) begin
                rd_data[p] = bus.WRITEDATA0;
            end
            if ((ZERO_REG != 0) && (rd_addr[p] == '0)) rd_data[p] = '0;
        end
    end

    assign bus.REGOUT1 = rd_data[0];
    assign bus.REGOUT2 = rd_data[1];
    assign bus.BUSY    = busy;
endmodule
